// File: rtl/scope_trace_buffer.sv
// Oscilloscope trace capture: trigger detection, decimated capture into a
// column buffer, and registered column-to-screen-row readout for the LCD.
module scope_trace_buffer #(
    parameter int DEPTH     = 240,
    parameter int TIMEOUT_W = 20
) (
    input  logic        clock,
    input  logic        rstApp,
    input  logic        sampleValid,
    input  logic [11:0] sampleData,
    input  logic [11:0] trigLevel,
    input  logic        trigEnable,
    input  logic [3:0]  decim,
    input  logic        frameDone,
    input  logic [7:0]  rdAddr,
    output logic [8:0]  rdY,
    output logic        bufferReady,
    output logic        captureBusy
);

    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);
    localparam logic [8:0]     DEPTH_9 = 9'(DEPTH);

    localparam logic [1:0] ARM     = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]           state;
    logic [AW-1:0]        wr_ptr;
    logic [3:0]           dec_cnt;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [11:0]          prev_sample;

    logic [7:0]           mem [DEPTH];

    logic                 crossing;
    logic                 trig;
    logic                 keep;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic                 rd_in_range;
    logic [AW-1:0]        rd_idx;
    logic [7:0]           rd_q;
    logic                 rd_oor_q;
    logic                 rd_live;

    // >= rather than == so that lowering decim mid-capture cannot make the
    // counter run past it and wrap through all 16 values.
    always_comb begin
        crossing    = (prev_sample < trigLevel) && (sampleData >= trigLevel);
        trig        = (state == ARM) && sampleValid &&
                      (!trigEnable || crossing || (tmo_cnt == '1));
        keep        = (state == CAPTURE) && sampleValid && (dec_cnt >= decim);
        wr_en       = trig || keep;
        wr_addr     = trig ? '0 : wr_ptr;
        rd_in_range = ({1'b0, rdAddr} < DEPTH_9);
        rd_idx      = rd_in_range ? AW'(rdAddr) : '0;
    end

    always_ff @(posedge clock or posedge rstApp) begin
        if (rstApp) begin
            state       <= ARM;
            wr_ptr      <= '0;
            dec_cnt     <= '0;
            tmo_cnt     <= '0;
            prev_sample <= '0;
        end else begin
            if (sampleValid) begin
                prev_sample <= sampleData;
            end
            case (state)
                ARM: begin
                    if (trig) begin
                        state   <= CAPTURE;
                        wr_ptr  <= AW'(1);
                        dec_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (keep) begin
                        dec_cnt <= '0;
                        if (wr_ptr == LAST) begin
                            state <= HOLD;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end else if (sampleValid) begin
                        dec_cnt <= dec_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (frameDone) begin
                        state   <= ARM;
                        wr_ptr  <= '0;
                        tmo_cnt <= '0;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    // Memory stays reset-free so it maps onto block RAM; the read-side reset
    // lives in the small flags below.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= sampleData[11:4];
        end
        rd_q <= mem[rd_idx];
    end

    always_ff @(posedge clock or posedge rstApp) begin
        if (rstApp) begin
            rd_live  <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rd_live  <= 1'b1;
            rd_oor_q <= !rd_in_range;
        end
    end

    always_comb begin
        if (!rd_live) begin
            rdY = '0;
        end else if (rd_oor_q) begin
            rdY = 9'd319;
        end else begin
            rdY = 9'd287 - {1'b0, rd_q};
        end
        bufferReady = (state == HOLD);
        captureBusy = (state == CAPTURE);
    end

endmodule

// File: doc/scope_trace_buffer.md
SCOPE_TRACE_BUFFER -- requirements
Module: scope_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 240, number of stored samples (one per LCD column).
REQ-002 SHALL have parameter TIMEOUT_W, default 20, auto-trigger timeout counter width.
REQ-003 SHALL have port clock  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL have port rstApp  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sampleValid  input  1  qualifies sampleData for one cycle.
REQ-006 SHALL have port sampleData  input  12  unsigned ADC sample.
REQ-007 SHALL have port trigLevel  input  12  rising-edge trigger threshold.
REQ-008 SHALL have port trigEnable  input  1  1 = wait for trigger, 0 = free-run.
REQ-009 SHALL have port decim  input  4  keep one of every decim+1 valid samples.
REQ-010 SHALL have port frameDone  input  1  single-cycle pulse from pixel generator: full frame drawn.
REQ-011 SHALL have port rdAddr  input  8  column index 0..DEPTH-1 from pixel generator.
REQ-012 SHALL have port rdY  output  9  screen row for column rdAddr, registered.
REQ-013 SHALL have port bufferReady  output  1  high while a complete capture is held.
REQ-014 SHALL have port captureBusy  output  1  high in CAPTURE state.

Function
REQ-015 SHALL implement states ARM, CAPTURE, HOLD; reset enters ARM.
REQ-016 SHALL register the last accepted valid sample as prevSample (all valid samples, not decimated).
REQ-017 In ARM, trigger SHALL fire on a valid sample where prevSample < trigLevel and sampleData >= trigLevel (unsigned).
REQ-018 In ARM with trigEnable=0, any valid sample SHALL fire the trigger.
REQ-019 In ARM, a TIMEOUT_W-bit counter SHALL increment every cycle; on reaching all-ones the next valid sample SHALL fire the trigger (auto mode).
REQ-020 The triggering sample SHALL be written to address 0; state becomes CAPTURE the next cycle with wrPtr=1, decimation counter=0, timeout counter=0.
REQ-021 In CAPTURE, each valid sample SHALL increment the decimation counter; when counter equals decim the sample SHALL be written at wrPtr, wrPtr incremented, counter cleared.
REQ-022 After the write at wrPtr=DEPTH-1, state SHALL become HOLD the next cycle; wrPtr SHALL never exceed DEPTH-1.
REQ-023 In HOLD, bufferReady SHALL be 1 and no writes SHALL occur; frameDone SHALL return to ARM next cycle.
REQ-024 frameDone in ARM or CAPTURE SHALL be ignored.
REQ-025 Stored value SHALL be sampleData[11:4] (8 bits).
REQ-026 rdY SHALL equal 9'd287 - stored[addr], range 32..287, valid one cycle after rdAddr is applied, in every state.
REQ-027 rdAddr >= DEPTH SHALL give rdY = 9'd319 (bottom row), no memory access error.
REQ-028 Reads during CAPTURE SHALL return current memory contents (mixed old/new); consumer gates on bufferReady.
REQ-029 Changes to decim, trigLevel, trigEnable SHALL take effect on the next accepted sample.
REQ-030 Memory SHALL be synchronous single-write/single-read, inferable as block RAM.

Reset
REQ-031 rstApp SHALL asynchronously force state ARM, wrPtr 0, decimation and timeout counters 0, prevSample 0, rdY 0, bufferReady 0, captureBusy 0.
REQ-032 rstApp mid-CAPTURE SHALL abandon the capture; memory contents are not cleared and are undefined after reset.
REQ-033 After release, first trigger SHALL require a fresh rising crossing relative to prevSample=0 (i.e. any sample >= trigLevel triggers if trigLevel > 0).

Verification
REQ-034 trigEnable=1, trigLevel=0x800, decim=0, ramp 0x7F0,0x800,... one sample/cycle -> address 0 holds 0x80, HOLD after 240 samples, rdAddr=0 gives rdY=287-128=159 next cycle.
REQ-035 decim=3, constant valid stream after trigger -> exactly every 4th sample stored, HOLD after 1+239*4 valid samples.
REQ-036 trigEnable=1, signal always 0x100 with trigLevel 0x800, TIMEOUT_W=4 -> auto-trigger on first valid sample after 15 ARM cycles.
REQ-037 In HOLD, sampleValid toggling with crossing data -> memory unchanged; frameDone pulse -> ARM next cycle, bufferReady 0.
REQ-038 rstApp asserted at wrPtr=100 -> all outputs reset values same cycle; rdAddr=250 -> rdY=319.
